// File: rtl/param_up_down_counter_if.sv
// rtl/param_up_down_counter_if.sv - control/status bundle for param_up_down_counter
interface param_up_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic             unf;
  logic             tc;

  modport master (
    output en, mode, load, load_val,
    input  count, ovf, unf, tc
  );

  modport slave (
    input  en, mode, load, load_val,
    output count, ovf, unf, tc
  );
endinterface

// File: rtl/param_up_down_counter.sv
// rtl/param_up_down_counter.sv - parametrised up/down counter with load, wrap/saturate and terminal count
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module param_up_down_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  param_up_down_counter_if.slave bus
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("param_up_down_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_up_down_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;
  logic             qual;
  logic             step;
  logic             at_max;
  logic             at_zero;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE) + 1;

  logic [PW-1:0] div_q;

  assign qual = (div_q == PW'(PRESCALE - 1));

  // Divider advances only on enabled, non-load cycles; load restarts the period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (bus.load) begin
      div_q <= '0;
    end else if (bus.en) begin
      if (qual) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + PW'(1);
      end
    end
  end
`else
  assign qual = 1'b1;
`endif

  assign at_max  = (count_q == MAX_V);
  assign at_zero = (count_q == '0);
  assign step    = bus.en & ~bus.load & qual;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else if (step) begin
      if (!bus.mode) begin
        if (at_max) begin
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? MAX_V : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          unf_d   = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_V;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // tc is combinational so a downstream stage's en sees it in the same cycle.
  assign bus.tc    = bus.en & qual & (bus.mode ? at_zero : at_max);
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule
